mic_sram_recorder: RTL and testbench

Records the 16-channel microphone array to the board SRAM. On each LRCK-rate frame tick it snapshots one PCM sample per channel and writes them as 16 consecutive SRAM words, generating addresses and write strobes. Start/stop and a two-bit state go to the top-level controls and the seven-segment state display. It sits between the per-channel decimators and the SRAM pins on the 50 MHz domain.

---
 rtl/dclab_pkg.sv | 19 +
 rtl/mic_sample_bank.sv | 36 +++
 rtl/mic_sram_recorder.sv | 200 ++++++++++++++++++++
 tb/tb_mic_sram_recorder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dclab_pkg.sv
// Shared constants and types for the microphone-array recorder.
//   MIC_NUMBER  channels per frame (power of two)
//   SAMPLE_W    PCM sample width, equal to the SRAM word width
//   CH_W        width of a channel index
//   rec_state_t recorder state; its 2-bit encoding is exported as o_state
package dclab_pkg;

    localparam int unsigned MIC_NUMBER = 16;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned CH_W       = $clog2(MIC_NUMBER);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        WRITE      = 2'd2,
        DONE       = 2'd3
    } rec_state_t;

endpackage

// File: rtl/mic_sample_bank.sv
// Snapshot register bank: captures one PCM sample per channel on load and
// holds them while load is low, so a frame can be streamed out word by word.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture all channels of sample this cycle
//   sample       flat per-channel PCM, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   rd_idx       channel to read
//   rd_data_c    combinational read of the selected channel
module mic_sample_bank
    import dclab_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [MIC_NUMBER*SAMPLE_W-1:0] sample,
    input  logic [CH_W-1:0]                rd_idx,
    output logic [SAMPLE_W-1:0]            rd_data_c
);

    logic [SAMPLE_W-1:0] bank_q [MIC_NUMBER];

    // Snapshot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MIC_NUMBER; k++) begin
                bank_q[k] <= '0;
            end
        end else if (load) begin
            for (int unsigned k = 0; k < MIC_NUMBER; k++) begin
                bank_q[k] <= sample[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign rd_data_c = bank_q[rd_idx];

endmodule

// File: rtl/mic_sram_recorder.sv
// Records one PCM sample per microphone channel per frame tick into SRAM as
// MIC_NUMBER consecutive words, two cycles per word (strobe low, then high
// with address and data held).
//   i_clk, i_rst_n        50 MHz clock, asynchronous active-low reset
//   i_start, i_stop       level controls
//   i_frame_tick          one-cycle frame pulse, synchronous to i_clk
//   i_sample              flat per-channel PCM, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   o_SRAM_*, io_SRAM_DQ  SRAM address, data and strobes (write-only use)
//   o_state               recorder state (rec_state_t encoding)
//   o_frames              frames completed since start
//   o_overrun, o_full     sticky status flags
module mic_sram_recorder
    import dclab_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_frame_tick,
    input  logic [MIC_NUMBER*SAMPLE_W-1:0] i_sample,
    output logic [ADDR_W-1:0]              o_SRAM_ADDR,
    inout  wire  [SAMPLE_W-1:0]            io_SRAM_DQ,
    output logic                           o_SRAM_WE_N,
    output logic                           o_SRAM_CE_N,
    output logic                           o_SRAM_OE_N,
    output logic                           o_SRAM_LB_N,
    output logic                           o_SRAM_UB_N,
    output logic [1:0]                     o_state,
    output logic [ADDR_W-CH_W-1:0]         o_frames,
    output logic                           o_overrun,
    output logic                           o_full
);

    localparam int unsigned FR_W = ADDR_W - CH_W;

    rec_state_t          state_q,     state_d;
    logic [CH_W-1:0]     ch_q,        ch_d;
    logic                phase_b_q,   phase_b_d;
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic                stop_seen_q, stop_seen_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                we_n_q,      we_n_d;
    logic [SAMPLE_W-1:0] dq_q,        dq_d;
    logic                dq_oe_q,     dq_oe_d;
    logic [FR_W-1:0]     frames_q,    frames_d;
    logic                overrun_q,   overrun_d;
    logic                full_q,      full_d;

    logic                bank_load_c;
    logic [CH_W-1:0]     ch_inc_c;
    logic [SAMPLE_W-1:0] bank_rd_c;
    logic [ADDR_W-1:0]   base_next_c;

    // Next channel drives the bank read so its word is registered at phase A
    assign ch_inc_c    = ch_q + CH_W'(1);
    assign base_next_c = base_q + ADDR_W'(MIC_NUMBER);

    mic_sample_bank u_bank (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (bank_load_c),
        .sample    (i_sample),
        .rd_idx    (ch_inc_c),
        .rd_data_c (bank_rd_c)
    );

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            phase_b_q   <= 1'b0;
            base_q      <= '0;
            stop_seen_q <= 1'b0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            frames_q    <= '0;
            overrun_q   <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            phase_b_q   <= phase_b_d;
            base_q      <= base_d;
            stop_seen_q <= stop_seen_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            frames_q    <= frames_d;
            overrun_q   <= overrun_d;
            full_q      <= full_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        phase_b_d   = phase_b_q;
        base_d      = base_q;
        stop_seen_d = stop_seen_q;
        addr_d      = addr_q;
        we_n_d      = 1'b1;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        frames_d    = frames_q;
        overrun_d   = overrun_q;
        full_d      = full_q;
        bank_load_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (i_start && !i_stop) begin
                    state_d     = WAIT_FRAME;
                    base_d      = '0;
                    addr_d      = '0;
                    frames_d    = '0;
                    overrun_d   = 1'b0;
                    full_d      = 1'b0;
                    stop_seen_d = 1'b0;
                end
            end

            WAIT_FRAME: begin
                if (i_frame_tick) begin
                    // Bank loads this edge, so channel 0 comes straight from the input
                    state_d     = WRITE;
                    bank_load_c = 1'b1;
                    ch_d        = '0;
                    phase_b_d   = 1'b0;
                    stop_seen_d = i_stop;
                    addr_d      = base_q;
                    we_n_d      = 1'b0;
                    dq_d        = i_sample[SAMPLE_W-1:0];
                    dq_oe_d     = 1'b1;
                end else if (i_stop) begin
                    state_d = DONE;
                end
            end

            WRITE: begin
                if (i_frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (i_stop) begin
                    stop_seen_d = 1'b1;
                end
                if (!phase_b_q) begin
                    phase_b_d = 1'b1;
                end else if (ch_q != CH_W'(MIC_NUMBER - 1)) begin
                    ch_d      = ch_inc_c;
                    phase_b_d = 1'b0;
                    addr_d    = base_q + ADDR_W'(ch_inc_c);
                    we_n_d    = 1'b0;
                    dq_d      = bank_rd_c;
                end else begin
                    // Frame complete: advance base, release the bus
                    ch_d      = '0;
                    phase_b_d = 1'b0;
                    base_d    = base_next_c;
                    frames_d  = frames_q + FR_W'(1);
                    dq_oe_d   = 1'b0;
                    if (base_next_c == '0) begin
                        full_d  = 1'b1;
                        state_d = DONE;
                    end else if (stop_seen_q || i_stop) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_state     = state_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_frames    = frames_q;
    assign o_overrun   = overrun_q;
    assign o_full      = full_q;

    // Write-only port: chip, byte lanes always enabled, output enable never
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_OE_N = 1'b1;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;

    assign io_SRAM_DQ = dq_oe_q ? dq_q : {SAMPLE_W{1'bz}};

endmodule

// File: tb/tb_mic_sram_recorder.sv
// Bench for mic_sram_recorder (ADDR_W=8 so memory-full is reachable).
// A frame-level reference model predicts status and the SRAM write stream;
// a table of scripted operations checks fixed expected values.
module tb_mic_sram_recorder;
    import dclab_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned FW = AW - CH_W;
    localparam logic [15:0] PROBE = 16'hC35A;

    localparam int OP_START     = 0;
    localparam int OP_TICK      = 1;
    localparam int OP_TICK_STOP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tick = 1'b0;
    logic [255:0]  samp = '0;
    logic          probe_en = 1'b0;
    wire  [15:0]   dq;
    logic [AW-1:0] addr;
    logic          we_n, ce_n, oe_n, lb_n, ub_n;
    logic [1:0]    st;
    logic [FW-1:0] frames;
    logic          ovr, full;

    int n_tests = 0;
    int n_fail  = 0;

    // A weak outside driver: reads back PROBE only if the DUT releases the bus
    assign dq = probe_en ? PROBE : 16'hzzzz;

    always #10 clk = ~clk;

    mic_sram_recorder #(.ADDR_W(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_frame_tick (tick),
        .i_sample     (samp),
        .o_SRAM_ADDR  (addr),
        .io_SRAM_DQ   (dq),
        .o_SRAM_WE_N  (we_n),
        .o_SRAM_CE_N  (ce_n),
        .o_SRAM_OE_N  (oe_n),
        .o_SRAM_LB_N  (lb_n),
        .o_SRAM_UB_N  (ub_n),
        .o_state      (st),
        .o_frames     (frames),
        .o_overrun    (ovr),
        .o_full       (full)
    );

    // ---------------- reference model ----------------
    int          m_state, m_rem, m_base, m_frames;
    bit          m_ovr, m_full, m_stop_seen;
    logic [23:0] exp_q [$];
    logic [23:0] last_wr;

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_base = 0; m_frames = 0;
        m_ovr = 0; m_full = 0; m_stop_seen = 0;
        exp_q.delete();
    endtask

    // Effect of the coming clock edge, given the inputs now applied
    task automatic model_step();
        case (m_state)
            0, 3: if (start && !stop) begin
                m_state = 1; m_base = 0; m_frames = 0; m_ovr = 0; m_full = 0;
            end
            1: if (tick) begin
                for (int k = 0; k < 16; k++)
                    exp_q.push_back({8'(m_base + k), samp[k*16 +: 16]});
                m_rem = 32; m_stop_seen = stop; m_state = 2;
            end else if (stop) begin
                m_state = 3;
            end
            default: begin
                if (tick) m_ovr = 1;
                if (stop) m_stop_seen = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_base   = (m_base + 16) % 256;
                    m_frames = (m_frames + 1) % 16;
                    if (m_base == 0) begin
                        m_full = 1; m_state = 3;
                    end else begin
                        m_state = m_stop_seen ? 3 : 1;
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input int idx, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d (0x%0h), want %0d (0x%0h)", name, idx, got, got, want, want);
        end
    endtask

    task automatic chk_dq_released(input string name, input int idx);
        probe_en = 1'b1;
        #1;
        chk(name, idx, int'(dq), int'(PROBE));
        probe_en = 1'b0;
    endtask

    // Per-cycle comparison against the model, sampled at the falling edge
    task automatic check_cycle();
        logic [23:0] got, want;
        n_tests++;
        if ({st, frames, ovr, full, ce_n, oe_n, lb_n, ub_n} !==
            {2'(m_state), FW'(m_frames), m_ovr, m_full, 4'b0100}) begin
            n_fail++;
            $display("FAIL status: got st=%0d fr=%0d ovr=%0b full=%0b strb=%b%b%b%b, want st=%0d fr=%0d ovr=%0b full=%0b strb=0100",
                     st, frames, ovr, full, ce_n, oe_n, lb_n, ub_n, m_state, m_frames, m_ovr, m_full);
        end
        if (we_n == 1'b0) begin
            got = {addr, dq};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, want no write", addr, dq);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                             got[23:16], got[15:0], want[23:16], want[15:0]);
                end
            end
            last_wr = got;
        end else if (st == 2'd2) begin
            n_tests++;
            if ({addr, dq} !== last_wr) begin
                n_fail++;
                $display("FAIL hold: got addr=%0d data=%h, want addr=%0d data=%h",
                         addr, dq, last_wr[23:16], last_wr[15:0]);
            end
        end
        if (m_state != 2) chk_dq_released("dq_release", 0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_pat(input int p);
        for (int k = 0; k < 16; k++) samp[k*16 +: 16] = 16'(p + k);
    endtask

    // ---------------- scripted table ----------------
    typedef struct {
        int op; int pat; int reps; int wait_n;
        int e_state; int e_frames; int e_ovr; int e_full; int e_addr;
    } vec_t;

    task automatic apply(input vec_t v, input int idx);
        case (v.op)
            OP_START: begin
                start = 1'b1; cycle(); start = 1'b0; cycle();
            end
            OP_TICK: begin
                for (int r = 0; r < v.reps; r++) begin
                    set_pat(v.pat + (r << 8));
                    tick = 1'b1; cycle(); tick = 1'b0;
                    repeat (v.wait_n) cycle();
                end
            end
            default: begin
                // stop pulsed during phase A of channel 5
                set_pat(v.pat);
                tick = 1'b1; cycle(); tick = 1'b0;
                repeat (10) cycle();
                stop = 1'b1; cycle(); stop = 1'b0;
                repeat (v.wait_n) cycle();
            end
        endcase
        chk("vec_state",   idx, int'(st),     v.e_state);
        chk("vec_frames",  idx, int'(frames), v.e_frames);
        chk("vec_overrun", idx, int'(ovr),    v.e_ovr);
        chk("vec_full",    idx, int'(full),   v.e_full);
        chk("vec_addr",    idx, int'(addr),   v.e_addr);
        if (v.e_state != 2) chk("vec_pending_writes", idx, exp_q.size(), 0);
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{OP_START,     0,       0,  0,  1, 0,  0, 0, 0};
        vecs[1]  = '{OP_TICK,      'h1000,  1,  40, 1, 1,  0, 0, 15};
        vecs[2]  = '{OP_TICK,      'h2000,  1,  40, 1, 2,  0, 0, 31};
        vecs[3]  = '{OP_TICK,      'h3000,  1,  9,  2, 2,  0, 0, 36};
        vecs[4]  = '{OP_TICK,      'h4000,  1,  40, 1, 3,  1, 0, 47};
        vecs[5]  = '{OP_TICK,      'h5000,  1,  40, 1, 4,  1, 0, 63};
        vecs[6]  = '{OP_TICK_STOP, 'h6000,  1,  40, 3, 5,  1, 0, 79};
        vecs[7]  = '{OP_TICK,      'h7000,  1,  40, 3, 5,  1, 0, 79};
        vecs[8]  = '{OP_START,     0,       0,  0,  1, 0,  0, 0, 0};
        vecs[9]  = '{OP_TICK,      'h8000,  15, 40, 1, 15, 0, 0, 239};
        vecs[10] = '{OP_TICK,      'h9000,  1,  40, 3, 0,  0, 1, 255};
        vecs[11] = '{OP_START,     0,       0,  0,  1, 0,  0, 0, 0};
        vecs[12] = '{OP_TICK,      'hA000,  1,  40, 1, 1,  0, 0, 15};

        model_reset();
        last_wr = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_state",  0, int'(st),     0);
        chk("rst_addr",   0, int'(addr),   0);
        chk("rst_we_n",   0, int'(we_n),   1);
        chk("rst_strobe", 0, int'({ce_n, oe_n, lb_n, ub_n}), 4);
        chk("rst_flags",  0, int'({frames, ovr, full}), 0);
        chk_dq_released("rst_dq", 0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 13; i++) apply(vecs[i], i);

        // Asynchronous reset in the middle of channel 7
        set_pat('hB000);
        tick = 1'b1; cycle(); tick = 1'b0;
        repeat (14) cycle();
        chk("pre_rst_we_n", 0, int'(we_n), 0);
        chk("pre_rst_addr", 0, int'(addr), 23);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n",   0, int'(we_n),   1);
        chk("mid_rst_state",  0, int'(st),     0);
        chk("mid_rst_frames", 0, int'(frames), 0);
        chk("mid_rst_addr",   0, int'(addr),   0);
        chk_dq_released("mid_rst_dq", 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply('{OP_START, 0,      0, 0,  1, 0, 0, 0, 0},  13);
        apply('{OP_TICK,  'hC000, 1, 40, 1, 1, 0, 0, 15}, 14);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 16; k++) samp[k*16 +: 16] = 16'($urandom);
            tick  = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 49) == 0);
            cycle();
        end
        tick = 1'b0; stop = 1'b0; start = 1'b0;
        repeat (40) cycle();
        chk("final_pending_writes", 0, exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
